// File: rtl/fp_add_sequencer_pkg.sv
// fp_add_sequencer_pkg: FSM encoding and default geometry shared by the
// add sequencer and its watchdog.
package fp_add_sequencer_pkg;

  localparam int DEF_RADIX  = 32;
  localparam int DEF_DIGITS = 14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_e;

endpackage

// File: rtl/fp_add_sequencer_watchdog.sv
// seq_watchdog: cycle counter that flags the last allowed cycle of a
// command so the sequencer can abort into REPORT on the next edge.
module seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter equals the number of run cycles already elapsed.
  assign expired_o = run_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: feeds operand digits into the add/compare datapath and
// collects result digits. Define FP_ADD_SEQ_WATCHDOG_EN for a timeout abort.
module fp_add_sequencer
  import fp_add_sequencer_pkg::*;
#(
  parameter int RADIX  = DEF_RADIX,
  parameter int DIGITS = DEF_DIGITS,
  parameter int ADDR_W = $clog2(DIGITS)
`ifdef FP_ADD_SEQ_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              cmd_carry_in,
  output logic              cmd_ready,
  output logic              cmd_done,
  output logic              cmd_carry_out,
  output logic              cmd_gt_const,
  output logic              cmd_err,
  output logic [ADDR_W-1:0] op_rd_addr,
  input  logic [RADIX-1:0]  op_a_dout,
  input  logic [RADIX-1:0]  op_b_dout,
  output logic              add_start,
  output logic              add_carry_in,
  output logic              add_digit_in_valid,
  output logic [RADIX-1:0]  add_digit_a,
  output logic [RADIX-1:0]  add_digit_b,
  input  logic              add_digit_out_valid,
  input  logic [RADIX-1:0]  add_digit_res,
  input  logic              add_gt_const,
  input  logic              add_carry_out,
  input  logic              add_done,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_wr_addr,
  output logic [RADIX-1:0]  res_wr_data
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS);

  state_e state_q, state_d;
  logic [CW-1:0] icnt_q, icnt_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic carry_q, carry_d;
  logic ovf_q, ovf_d;
  logic co_q, co_d;
  logic gt_q, gt_d;
  logic err_q, err_d;
  logic accept, running, issue, tout, wd_exp;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign running = (state_q == START) || (state_q == FEED)
                || (state_q == DRAIN);
  assign issue   = (state_q == START)
                || ((state_q == FEED) && (icnt_q != LAST));

`ifdef FP_ADD_SEQ_WATCHDOG_EN
  seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .run_i    (running),
    .expired_o(wd_exp)
  );
`else
  assign wd_exp = 1'b0;
`endif

  // A done in the same cycle as expiry counts as a normal finish.
  assign tout = wd_exp && !add_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = START;
      START:   state_d = FEED;
      FEED:    if (icnt_q == LAST) state_d = DRAIN;
      DRAIN:   state_d = DRAIN;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (running && (add_done || tout)) begin
      state_d = REPORT;
    end
  end

  always_comb begin
    cmd_ready          = (state_q == IDLE);
    cmd_done           = (state_q == REPORT);
    add_start          = (state_q == START);
    add_carry_in       = add_start && carry_q;
    add_digit_in_valid = (state_q == FEED);
    add_digit_a        = add_digit_in_valid ? op_a_dout : '0;
    add_digit_b        = add_digit_in_valid ? op_b_dout : '0;
    op_rd_addr         = issue ? icnt_q[ADDR_W-1:0] : '0;
    res_wr_en          = running && add_digit_out_valid
                      && (wcnt_q != LAST);
    res_wr_addr        = res_wr_en ? wcnt_q[ADDR_W-1:0] : '0;
    res_wr_data        = res_wr_en ? add_digit_res : '0;
  end

  assign cmd_carry_out = co_q;
  assign cmd_gt_const  = gt_q;
  assign cmd_err       = err_q;

  always_comb begin
    carry_d = carry_q;
    icnt_d  = icnt_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    co_d    = co_q;
    gt_d    = gt_q;
    err_d   = err_q;
    if (accept) begin
      carry_d = cmd_carry_in;
      icnt_d  = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
      co_d    = 1'b0;
      gt_d    = 1'b0;
      err_d   = 1'b0;
    end
    if (issue) begin
      icnt_d = icnt_q + 1'b1;
    end
    if (running && add_digit_out_valid) begin
      if (wcnt_q == LAST) begin
        ovf_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    if (running && add_done) begin
      co_d = add_carry_out;
      gt_d = add_gt_const;
    end
    // Early done (before DRAIN) is an error even if the count matches.
    if (running && (state_d == REPORT)) begin
      err_d = (wcnt_d != LAST) || ovf_d || tout
           || (state_q != DRAIN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt_q  <= '0;
      wcnt_q  <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      co_q    <= 1'b0;
      gt_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      icnt_q  <= icnt_d;
      wcnt_q  <= wcnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      co_q    <= co_d;
      gt_q    <= gt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: directed and random commands against a serial
// adder model; build with +define+FP_ADD_SEQ_WATCHDOG_EN for the abort path.
`timescale 1ns/1ps
module tb_fp_add_sequencer;

  localparam int RADIX   = 32;
  localparam int DIGITS  = 14;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 64;
  localparam int NB      = RADIX * DIGITS;
  // accept -> START, DIGITS feed cycles, one model cycle, then REPORT
  localparam int LAT     = DIGITS + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_carry_in = 1'b0;
  logic cmd_ready, cmd_done, cmd_carry_out, cmd_gt_const, cmd_err;
  logic [ADDR_W-1:0] op_rd_addr;
  logic [RADIX-1:0] op_a_dout = '0;
  logic [RADIX-1:0] op_b_dout = '0;
  logic add_start, add_carry_in, add_digit_in_valid;
  logic [RADIX-1:0] add_digit_a, add_digit_b;
  logic add_digit_out_valid = 1'b0;
  logic [RADIX-1:0] add_digit_res = '0;
  logic add_gt_const = 1'b0;
  logic add_carry_out = 1'b0;
  logic add_done = 1'b0;
  logic res_wr_en;
  logic [ADDR_W-1:0] res_wr_addr;
  logic [RADIX-1:0] res_wr_data;

  always #5 clk = ~clk;

  fp_add_sequencer #(
    .RADIX (RADIX),
    .DIGITS(DIGITS),
    .ADDR_W(ADDR_W)
`ifdef FP_ADD_SEQ_WATCHDOG_EN
    ,
    .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_carry_in       (cmd_carry_in),
    .cmd_ready          (cmd_ready),
    .cmd_done           (cmd_done),
    .cmd_carry_out      (cmd_carry_out),
    .cmd_gt_const       (cmd_gt_const),
    .cmd_err            (cmd_err),
    .op_rd_addr         (op_rd_addr),
    .op_a_dout          (op_a_dout),
    .op_b_dout          (op_b_dout),
    .add_start          (add_start),
    .add_carry_in       (add_carry_in),
    .add_digit_in_valid (add_digit_in_valid),
    .add_digit_a        (add_digit_a),
    .add_digit_b        (add_digit_b),
    .add_digit_out_valid(add_digit_out_valid),
    .add_digit_res      (add_digit_res),
    .add_gt_const       (add_gt_const),
    .add_carry_out      (add_carry_out),
    .add_done           (add_done),
    .res_wr_en          (res_wr_en),
    .res_wr_addr        (res_wr_addr),
    .res_wr_data        (res_wr_data)
  );

  logic [RADIX-1:0] mem_a [DIGITS];
  logic [RADIX-1:0] mem_b [DIGITS];
  logic [RADIX-1:0] res_mem [DIGITS];
  logic [NB:0] p2;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int n_wr = 0;
  int n_inv = 0;
  int start_cyc[$];

  always @(posedge clk) begin
    op_a_dout <= mem_a[op_rd_addr];
    op_b_dout <= mem_b[op_rd_addr];
    if (res_wr_en) res_mem[res_wr_addr] <= res_wr_data;
  end

  always @(negedge clk) begin
    cyc++;
    if (add_start) begin
      n_start++;
      start_cyc.push_back(cyc);
    end
    if (cmd_done) n_done++;
    if (res_wr_en) n_wr++;
    if (add_digit_in_valid) n_inv++;
  end

  // Serial adder/comparator model. mode 1 drops the last result digit,
  // mode 2 never signals add_done.
  logic m_c;
  int m_n;
  logic [NB-1:0] m_sum;
  logic [RADIX:0] m_s;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      add_digit_out_valid <= 1'b0;
      add_digit_res <= '0;
      add_done <= 1'b0;
      add_carry_out <= 1'b0;
      add_gt_const <= 1'b0;
      m_c = 1'b0;
      m_n = 0;
      m_sum = '0;
    end else begin
      add_digit_out_valid <= 1'b0;
      add_done <= 1'b0;
      add_carry_out <= 1'b0;
      add_gt_const <= 1'b0;
      if (add_start) begin
        m_c = add_carry_in;
        m_n = 0;
        m_sum = '0;
      end
      if (add_digit_in_valid && m_n < DIGITS) begin
        m_s = {1'b0, add_digit_a} + {1'b0, add_digit_b}
            + {{RADIX{1'b0}}, m_c};
        m_c = m_s[RADIX];
        m_sum[m_n*RADIX +: RADIX] = m_s[RADIX-1:0];
        m_n++;
        if (!(mode == 1 && m_n == DIGITS)) begin
          add_digit_out_valid <= 1'b1;
          add_digit_res <= m_s[RADIX-1:0];
        end
        if (m_n == DIGITS && mode != 2) begin
          add_done <= 1'b1;
          add_carry_out <= m_c;
          add_gt_const <= ({m_c, m_sum} > p2);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB:0] ref_sum(input logic cin);
    logic [NB:0] va, vb, vc;
    va = '0;
    vb = '0;
    vc = '0;
    vc[0] = cin;
    for (int i = 0; i < DIGITS; i++) begin
      va[i*RADIX +: RADIX] = mem_a[i];
      vb[i*RADIX +: RADIX] = mem_b[i];
    end
    return va + vb + vc;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < DIGITS; i++) begin
      if (kind == 0) begin
        mem_a[i] = 32'h0000_0001;
        mem_b[i] = 32'h0000_0002;
      end else if (kind == 1) begin
        mem_a[i] = 32'hFFFF_FFFF;
        mem_b[i] = (i == 0) ? 32'h1 : 32'h0;
      end else begin
        mem_a[i] = $urandom;
        mem_b[i] = $urandom;
      end
      res_mem[i] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run_cmd(input string tag, input logic cin,
                         input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "/ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_carry_in = cin;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_carry_in = 1'b0;
    lat = 1;
    while (!cmd_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/lat"}, lat, exp_lat);
  endtask

  task automatic cmd_check(input string tag, input logic cin,
                           input bit exp_err);
    logic [NB:0] e;
    int w0, d0;
    w0 = n_wr;
    d0 = n_done;
    run_cmd(tag, cin, LAT);
    e = ref_sum(cin);
    for (int i = 0; i < DIGITS; i++) begin
      if (!exp_err || i < DIGITS - 1)
        check($sformatf("%s/res%0d", tag, i), res_mem[i],
              e[i*RADIX +: RADIX]);
    end
    check({tag, "/writes"}, n_wr - w0, exp_err ? DIGITS - 1 : DIGITS);
    check({tag, "/carry"}, cmd_carry_out, e[NB]);
    check({tag, "/gt"}, cmd_gt_const, e > p2);
    check({tag, "/err"}, cmd_err, exp_err);
    @(negedge clk);
    check({tag, "/one_done"}, n_done - d0, 1);
    check({tag, "/idle"}, cmd_ready, 1);
    check({tag, "/held_err"}, cmd_err, exp_err);
  endtask

  initial begin
    int acc, s0, d0, i0, w0;
    logic [NB:0] e;
    p2 = '0;
    p2[NB-1] = 1'b1;
    fill(0);

    repeat (3) @(negedge clk);
    check("rst/ready", cmd_ready, 1);
    check("rst/done", cmd_done, 0);
    check("rst/start", add_start, 0);
    check("rst/valid", add_digit_in_valid, 0);
    check("rst/wr", res_wr_en, 0);
    check("rst/err", cmd_err, 0);
    check("rst/addr", op_rd_addr, 0);
    rst = 1'b0;

    fill(0);
    cmd_check("t1", 1'b0, 1'b0);
    fill(1);
    cmd_check("t2", 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      fill(2);
      cmd_check($sformatf("rnd%0d", k), 1'($urandom_range(1, 0)), 1'b0);
    end

    // Three back-to-back commands with cmd_valid held high.
    fill(2);
    acc = 0;
    s0 = start_cyc.size();
    d0 = n_done;
    i0 = n_inv;
    @(negedge clk);
    cmd_valid = 1'b1;
    for (int k = 0; k < 3 * (LAT + 1) + 10 && n_done - d0 < 3; k++) begin
      if (cmd_ready && cmd_valid) acc++;
      else if (acc == 3) cmd_valid = 1'b0;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t3/accepts", acc, 3);
    check("t3/dones", n_done - d0, 3);
    check("t3/starts", start_cyc.size() - s0, 3);
    check("t3/digits", n_inv - i0, 3 * DIGITS);
    if (start_cyc.size() >= s0 + 3) begin
      check("t3/gap1", start_cyc[s0+1] - start_cyc[s0], LAT + 1);
      check("t3/gap2", start_cyc[s0+2] - start_cyc[s0+1], LAT + 1);
    end
    e = ref_sum(1'b0);
    for (int i = 0; i < DIGITS; i++)
      check($sformatf("t3/res%0d", i), res_mem[i], e[i*RADIX +: RADIX]);

    // Reset in the middle of the feed phase.
    fill(2);
    i0 = n_inv;
    d0 = n_done;
    @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && n_inv - i0 < 5; k++) @(negedge clk);
    check("t4/feeding", add_digit_in_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("t4/valid0", add_digit_in_valid, 0);
    check("t4/a0", add_digit_a, 0);
    check("t4/addr0", op_rd_addr, 0);
    check("t4/wr0", res_wr_en, 0);
    check("t4/ready1", cmd_ready, 1);
    @(negedge clk);
    w0 = n_wr;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("t4/nowr", n_wr - w0, 0);
    check("t4/nodone", n_done - d0, 0);
    fill(0);
    cmd_check("t4/after", 1'b0, 1'b0);

    // Datapath loses one result digit.
    mode = 1;
    fill(2);
    cmd_check("t5", 1'b1, 1'b1);
    mode = 0;

    // Datapath never finishes.
    mode = 2;
    fill(2);
`ifdef FP_ADD_SEQ_WATCHDOG_EN
    w0 = n_wr;
    run_cmd("t6", 1'b0, TIMEOUT + 1);
    check("t6/err", cmd_err, 1);
    check("t6/carry", cmd_carry_out, 0);
    check("t6/gt", cmd_gt_const, 0);
    check("t6/writes", n_wr - w0, DIGITS);
    @(negedge clk);
    check("t6/idle", cmd_ready, 1);
`else
    d0 = n_done;
    @(negedge clk);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (150) @(negedge clk);
    check("t6/stuck", cmd_ready, 0);
    check("t6/nodone", n_done - d0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    mode = 0;
    fill(2);
    cmd_check("t7", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
